// File: rtl/jogo_pkg.sv
// -----------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the game's input stage, control unit and datapath:
//   - FSM state encodings of the play detector (3 bits, exposed on db_estado)
//   - default number of player buttons
//   - one-hot test, also used by the datapath comparator
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package jogo_pkg;

    localparam int N_BOTOES_PADRAO = 4;

    localparam logic [2:0] OCIOSO         = 3'b000;
    localparam logic [2:0] FILTRANDO      = 3'b001;
    localparam logic [2:0] EMITE          = 3'b010;
    localparam logic [2:0] AGUARDA_SOLTAR = 3'b011;
    localparam logic [2:0] SOLTANDO       = 3'b100;

    // True when exactly one bit is set. Narrower vectors are zero-extended
    // by the caller; clearing the lowest set bit must leave nothing behind.
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchronizer chain for asynchronous level inputs. Each bit is
// synchronized independently; q is d delayed by two rising edges.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high; clears both stages to 0
//   d      in   WIDTH asynchronous levels
//   q      out  WIDTH synchronized levels
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sinc_q;

    // NOTE: non-blocking assignments make both stages sample their inputs at
    // the same edge, so the chain really is two flops deep.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= d;
            sinc_q <= meta_q;
        end
    end

    assign q = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Input stage ahead of the game control unit. Synchronizes and debounces the
// raw player buttons, emits one single-cycle jogada_feita pulse per valid
// (exactly one-hot) press and keeps the one-hot code of the last accepted
// press for the datapath comparator. A press must be released, and the
// all-zero level must be stable for DEBOUNCE_CICLOS cycles, before another
// press can be accepted.
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-high; returns to OCIOSO
//   botoes          in   N_BOTOES raw asynchronous button levels, active-high
//   jogada_feita    out  single-cycle pulse: valid one-hot press accepted
//   jogada_codigo   out  N_BOTOES one-hot code of last accepted press
//   db_estado       out  3-bit current FSM state, for debug displays
//   db_botoes_sinc  out  N_BOTOES synchronized button levels, for debug LEDs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada_feita,
    output logic [N_BOTOES-1:0] jogada_codigo,
    output logic [2:0]          db_estado,
    output logic [N_BOTOES-1:0] db_botoes_sinc
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sinc;

    logic [2:0]          estado_q, estado_d;
    logic [N_BOTOES-1:0] padrao_q, padrao_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [N_BOTOES-1:0] codigo_q, codigo_d;

    sincronizador_2ff #(
        .WIDTH (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (sinc)
    );

    // NOTE: every next-state signal is defaulted to its current value first,
    // so paths that leave a register untouched cannot infer a latch.
    always_comb begin
        estado_d = estado_q;
        padrao_d = padrao_q;
        cnt_d    = cnt_q;
        codigo_d = codigo_q;

        case (estado_q)
            OCIOSO: begin
                if (sinc != '0) begin
                    estado_d = FILTRANDO;
                    padrao_d = sinc;
                    cnt_d    = '0;
                end
            end

            FILTRANDO: begin
                // Any change of the pattern, including a bounce, restarts from idle.
                if (sinc != padrao_q) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Chords are debounced like a press but never reported.
                    if (eh_one_hot(32'(padrao_q))) begin
                        estado_d = EMITE;
                        codigo_d = padrao_q;
                    end else begin
                        estado_d = AGUARDA_SOLTAR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            EMITE: begin
                estado_d = AGUARDA_SOLTAR;
            end

            AGUARDA_SOLTAR: begin
                if (sinc == '0) begin
                    estado_d = SOLTANDO;
                    cnt_d    = '0;
                end
            end

            SOLTANDO: begin
                // A bounce during release falls back to waiting; the held
                // press is never re-reported.
                if (sinc != '0) begin
                    estado_d = AGUARDA_SOLTAR;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // NOTE: jogada_codigo is reset along with the FSM so that a reset in the
    // middle of a play leaves no stale code for the comparator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            padrao_q <= '0;
            cnt_q    <= '0;
            codigo_q <= '0;
        end else begin
            estado_q <= estado_d;
            padrao_q <= padrao_d;
            cnt_q    <= cnt_d;
            codigo_q <= codigo_d;
        end
    end

    assign jogada_feita   = (estado_q == EMITE);
    assign jogada_codigo  = codigo_q;
    assign db_estado      = estado_q;
    assign db_botoes_sinc = sinc;

endmodule

// File: tb/tb_detector_jogada.sv
`timescale 1ns/1ps

module tb_detector_jogada;
    import jogo_pkg::*;

    localparam int NB = 4;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic          jogada_feita;
    logic [NB-1:0] jogada_codigo;
    logic [2:0]    db_estado;
    logic [NB-1:0] db_botoes_sinc;

    always #5 clock = ~clock;

    detector_jogada #(
        .N_BOTOES        (NB),
        .DEBOUNCE_CICLOS (DB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botoes         (botoes),
        .jogada_feita   (jogada_feita),
        .jogada_codigo  (jogada_codigo),
        .db_estado      (db_estado),
        .db_botoes_sinc (db_botoes_sinc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: a "press phase" (armed) in which a nonzero
    // sample opens a window that must see the same pattern DB more times,
    // and a "release phase" in which a zero sample opens a window that must
    // see zero DB more times. A one-hot accepted pattern produces one pulse
    // cycle before the release phase. Sampled level = botoes two edges ago.
    // ------------------------------------------------------------------
    typedef struct {
        bit            armed;
        bit            in_window;
        bit            pulse;
        logic [NB-1:0] cand;
        logic [NB-1:0] code;
        logic [NB-1:0] h1;
        logic [NB-1:0] h2;
        int            seen;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.armed = 1'b1; r.in_window = 1'b0; r.pulse = 1'b0;
        r.cand = '0; r.code = '0; r.h1 = '0; r.h2 = '0; r.seen = 0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t c, input logic [NB-1:0] b);
        model_t n;
        logic [NB-1:0] s;
        n = c;
        s = c.h2;
        if (c.pulse) begin
            n.pulse = 1'b0;
            n.in_window = 1'b0;
        end else if (c.armed) begin
            if (!c.in_window) begin
                if (s != 0) begin
                    n.in_window = 1'b1; n.cand = s; n.seen = 0;
                end
            end else if (s != c.cand) begin
                n.in_window = 1'b0;
            end else if (c.seen + 1 >= DB) begin
                n.in_window = 1'b0;
                n.armed = 1'b0;
                if ($countones(c.cand) == 1) begin
                    n.pulse = 1'b1;
                    n.code = c.cand;
                end
            end else begin
                n.seen = c.seen + 1;
            end
        end else begin
            if (!c.in_window) begin
                if (s == 0) begin
                    n.in_window = 1'b1; n.seen = 0;
                end
            end else if (s != 0) begin
                n.in_window = 1'b0;
            end else if (c.seen + 1 >= DB) begin
                n.in_window = 1'b0;
                n.armed = 1'b1;
            end else begin
                n.seen = c.seen + 1;
            end
        end
        n.h2 = c.h1;
        n.h1 = b;
        return n;
    endfunction

    function automatic logic [2:0] model_state(input model_t c);
        if (c.pulse)  return EMITE;
        if (c.armed)  return c.in_window ? FILTRANDO : OCIOSO;
        return c.in_window ? SOLTANDO : AGUARDA_SOLTAR;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, botoes);
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison and pulse bookkeeping (away from the active edge)
    // ------------------------------------------------------------------
    bit chk_en = 1'b0;
    int edge_n = 0;
    int pulse_cnt = 0;
    int last_pulse_edge = -1;

    always @(posedge clock) edge_n <= edge_n + 1;

    always @(negedge clock) begin
        if (chk_en) begin
            check("jogada_feita",   32'(jogada_feita),   32'(m.pulse));
            check("jogada_codigo",  32'(jogada_codigo),  32'(m.code));
            check("db_estado",      32'(db_estado),      32'(model_state(m)));
            check("db_botoes_sinc", 32'(db_botoes_sinc), 32'(m.h2));
        end
        if (jogada_feita) begin
            pulse_cnt       <= pulse_cnt + 1;
            last_pulse_edge <= edge_n;
        end
    end

    // Every call starts and ends 1 time unit after a rising edge.
    task automatic hold(input logic [NB-1:0] v, input int n);
        botoes = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        botoes = '0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    int base;
    int p0;

    initial begin
        #1 reset = 1'b1;
        #1;
        chk_en = 1'b1;
        #1;
        check("reset jogada_feita",  32'(jogada_feita),  32'd0);
        check("reset jogada_codigo", 32'(jogada_codigo), 32'd0);
        check("reset db_estado",     32'(db_estado),     32'd0);
        check("reset sinc",          32'(db_botoes_sinc), 32'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        hold('0, 3);

        // 1: clean press, latency DB+3 to EMITE, pulse in the next cycle
        base = edge_n; p0 = pulse_cnt;
        hold(4'b0010, 20);
        check("s1 pulses",      32'(pulse_cnt - p0),         32'd1);
        check("s1 pulse edge",  32'(last_pulse_edge - base), 32'd7);
        check("s1 codigo",      32'(jogada_codigo),          32'h2);
        check("s1 model code",  32'(m.code),                 32'h2);
        check("s1 held state",  32'(db_estado),              32'(AGUARDA_SOLTAR));
        hold('0, 10);
        check("s1 idle state",  32'(db_estado),              32'(OCIOSO));

        // 3: chord is debounced but not reported
        p0 = pulse_cnt;
        hold(4'b0101, 10);
        check("s3 held state",  32'(db_estado),              32'(AGUARDA_SOLTAR));
        hold('0, 10);
        check("s3 pulses",      32'(pulse_cnt - p0),         32'd0);
        check("s3 codigo kept", 32'(jogada_codigo),          32'h2);
        check("s3 idle state",  32'(db_estado),              32'(OCIOSO));

        // 4: long hold fires once
        p0 = pulse_cnt;
        hold(4'b1000, 30);
        check("s4 pulses held", 32'(pulse_cnt - p0),         32'd1);
        hold('0, 3);
        check("s4 soltando",    32'(db_estado),              32'(SOLTANDO));
        check("s4 model state", 32'(model_state(m)),         32'(SOLTANDO));
        hold('0, 10);
        check("s4 pulses end",  32'(pulse_cnt - p0),         32'd1);
        check("s4 codigo",      32'(jogada_codigo),          32'h8);

        // 5: release bounce, then a second accepted press
        p0 = pulse_cnt;
        hold(4'b0001, 10);
        hold('0, 1);
        hold(4'b0001, 1);
        hold('0, 8);
        hold(4'b0100, 10);
        hold('0, 10);
        check("s5 pulses",      32'(pulse_cnt - p0),         32'd2);
        check("s5 codigo",      32'(jogada_codigo),          32'h4);

        // 2: bouncing press never accepted
        pulse_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            hold(4'b0001, 2);
            hold(4'b0000, 2);
        end
        hold('0, 10);
        check("s2 pulses",      32'(pulse_cnt - p0),         32'd0);
        check("s2 codigo",      32'(jogada_codigo),          32'd0);
        check("s2 state",       32'(db_estado),              32'(OCIOSO));

        // 6: reset in the middle of filtering
        hold(4'b1000, 10);
        hold('0, 10);
        check("s6 pre codigo",  32'(jogada_codigo),          32'h8);
        p0 = pulse_cnt;
        hold(4'b0010, 5);
        check("s6 filtrando",   32'(db_estado),              32'(FILTRANDO));
        reset = 1'b1;
        botoes = '0;
        #1;
        check("s6 rst feita",   32'(jogada_feita),           32'd0);
        check("s6 rst codigo",  32'(jogada_codigo),          32'd0);
        check("s6 rst estado",  32'(db_estado),              32'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        hold('0, 3);
        check("s6 no pulse",    32'(pulse_cnt - p0),         32'd0);
        base = edge_n; p0 = pulse_cnt;
        hold(4'b0010, 20);
        check("s6 pulses",      32'(pulse_cnt - p0),         32'd1);
        check("s6 pulse edge",  32'(last_pulse_edge - base), 32'd7);
        check("s6 codigo",      32'(jogada_codigo),          32'h2);
        hold('0, 10);

        // Randomized phase, checked every cycle against the model
        begin
            logic [NB-1:0] v;
            v = '0;
            for (int k = 0; k < 400; k++) begin
                case ($urandom_range(0, 3))
                    0: v = '0;
                    1: v = NB'(1 << $urandom_range(0, NB - 1));
                    2: v = NB'($urandom);
                    default: ;
                endcase
                if ($urandom_range(0, 99) == 0) pulse_reset();
                hold(v, $urandom_range(1, 8));
            end
        end
        hold('0, 10);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete, got t=%0t, expected end before", $time);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
